// File: rtl/bf16_pkg.sv
// Shared types and parameter defaults for the bfloat16 adder driver.
package bf16_pkg;
  localparam int BF16_W      = 16;
  localparam int DEPTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 64;

  typedef logic [BF16_W-1:0] bf16_t;

  typedef struct packed {
    bf16_t a;
    bf16_t b;
  } op_pair_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push_s, do_pop_s;

  // A push at full is accepted only when a pop frees the slot on the same edge.
  assign do_pop_s  = pop_i & ~empty_o;
  assign do_push_s = push_i & (~full_o | do_pop_s);
  assign full_o    = (count_q == CNT_FULL);
  assign empty_o   = (count_q == {(AW+1){1'b0}});
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop_s) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/bf16_add_driver.sv
// Feeds queued operand pairs to a pulse-driven bfloat16 adder and buffers its results.
// Optional watchdog on the adder response: define BF16_DRV_TIMEOUT_EN.
module bf16_add_driver
  import bf16_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic  clock,
  input  logic  nreset,
  input  logic  op_valid,
  output logic  op_ready,
  input  bf16_t op_a,
  input  bf16_t op_b,
  output logic  res_valid,
  input  logic  res_ready,
  output bf16_t res_sum,
  output bf16_t add_a,
  output bf16_t add_b,
  input  bf16_t add_sum,
  input  logic  add_ready,
  output logic  busy
`ifdef BF16_DRV_TIMEOUT_EN
  ,
  output logic  timeout_err
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 8 || TIMEOUT > 255) begin : g_bad_params
    $error("bf16_add_driver: DEPTH or TIMEOUT out of range");
  end

  op_pair_t      op_wdata_s, op_head_s;
  logic          op_push_s, op_full_s, op_empty_s;
  logic [CW-1:0] op_count_s;
  logic          res_full_s, res_empty_s, res_pop_s;
  logic [1:0]    res_count_s;
  logic          inflight_q, inflight_d;
  bf16_t         issued_b_q, issued_b_d;
  logic          capture_s, room_s, issue_ok_s, issue_s, timeout_hit_s;

  assign op_wdata_s = '{a: op_a, b: op_b};
  assign op_push_s  = op_valid & op_ready;
  assign op_ready   = ~op_full_s;
  assign res_valid  = ~res_empty_s;
  assign res_pop_s  = res_valid & res_ready;
  assign busy       = inflight_q | (op_count_s != {CW{1'b0}});

  // The in-flight result will occupy a slot when it lands, so reserve it before issuing another.
  assign capture_s  = add_ready & inflight_q;
  assign room_s     = inflight_q ? (res_count_s == 2'd0) : ~res_full_s;
  assign issue_ok_s = ~op_empty_s & room_s;
  assign issue_s    = add_ready & issue_ok_s;
  assign add_a      = issue_ok_s ? op_head_s.a : 16'h0000;
  assign add_b      = issued_b_q;

  sync_fifo #(.WIDTH(2*BF16_W), .DEPTH(DEPTH)) u_op_fifo (
    .clock   (clock),
    .nreset  (nreset),
    .push_i  (op_push_s),
    .wdata_i (op_wdata_s),
    .pop_i   (issue_s),
    .rdata_o (op_head_s),
    .full_o  (op_full_s),
    .empty_o (op_empty_s),
    .count_o (op_count_s)
  );

  sync_fifo #(.WIDTH(BF16_W), .DEPTH(2)) u_res_fifo (
    .clock   (clock),
    .nreset  (nreset),
    .push_i  (capture_s),
    .wdata_i (add_sum),
    .pop_i   (res_pop_s),
    .rdata_o (res_sum),
    .full_o  (res_full_s),
    .empty_o (res_empty_s),
    .count_o (res_count_s)
  );

`ifdef BF16_DRV_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wd_q, wd_d;
  logic       err_q, err_d;

  always_comb begin
    wd_d          = wd_q;
    err_d         = err_q;
    timeout_hit_s = 1'b0;
    if (!inflight_q || add_ready) begin
      wd_d = 8'd0;
    end else if (wd_q == WD_LAST) begin
      wd_d          = 8'd0;
      err_d         = 1'b1;
      timeout_hit_s = 1'b1;
    end else begin
      wd_d = wd_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wd_q  <= 8'd0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Each pulse retires the outstanding op (if any) and may start the next one.
  always_comb begin
    inflight_d = inflight_q;
    issued_b_d = issued_b_q;
    if (add_ready) begin
      inflight_d = issue_s;
    end else if (timeout_hit_s) begin
      inflight_d = 1'b0;
    end else begin
      inflight_d = inflight_q;
    end
    if (issue_s) begin
      issued_b_d = op_head_s.b;
    end else begin
      issued_b_d = issued_b_q;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      inflight_q <= 1'b0;
      issued_b_q <= 16'h0000;
    end else begin
      inflight_q <= inflight_d;
      issued_b_q <= issued_b_d;
    end
  end
endmodule

// File: tb/tb_bf16_add_driver.sv
// Self-checking bench for bf16_add_driver with a pulse-protocol adder model and result scoreboard.
module tb_bf16_add_driver;
  import bf16_pkg::*;

  logic  clock = 1'b0;
  logic  nreset, op_valid, op_ready, res_valid, res_ready, add_ready, busy;
  bf16_t op_a, op_b, res_sum, add_a, add_b, add_sum;
  logic  gen_pulse, man_pulse, pulse_en;
`ifdef BF16_DRV_TIMEOUT_EN
  logic  timeout_err;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  bf16_t exp_q[$];

  typedef struct {
    bf16_t a;
    bf16_t b;
    bf16_t s;
  } vec_t;
  vec_t vecs[6];

  always #5 clock = ~clock;
  assign add_ready = gen_pulse | man_pulse;

  bf16_add_driver #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clock     (clock),
    .nreset    (nreset),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .add_ready (add_ready),
    .busy      (busy)
`ifdef BF16_DRV_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  // Truncating bfloat16 add for positive normal operands.
  function automatic bf16_t bf_add(input bf16_t x, input bf16_t y);
    bf16_t t;
    logic [7:0] ea, eb, d, ma, mb;
    logic [8:0] s;
    if (x[14:7] < y[14:7]) begin
      t = x; x = y; y = t;
    end
    ea = x[14:7]; eb = y[14:7];
    ma = {1'b1, x[6:0]}; mb = {1'b1, y[6:0]};
    d  = ea - eb;
    mb = (d > 8'd7) ? 8'h00 : (mb >> d);
    s  = {1'b0, ma} + {1'b0, mb};
    if (s[8]) return {1'b0, ea + 8'd1, s[7:1]};
    else      return {1'b0, ea, s[6:0]};
  endfunction

  // Adder model: a pulse samples add_a, the next edge samples add_b; sum shows up for the next pulse.
  logic  m_pend;
  bf16_t m_a;
  always @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      m_pend  <= 1'b0;
      m_a     <= 16'h0000;
      add_sum <= 16'h0000;
    end else begin
      if (m_pend) add_sum <= bf_add(m_a, add_b);
      m_pend <= add_ready;
      if (add_ready) m_a <= add_a;
    end
  end

  // Periodic pulse source, one pulse every 4 cycles when enabled.
  initial begin
    int cnt;
    cnt = 0;
    gen_pulse = 1'b0;
    forever begin
      @(negedge clock);
      cnt = (cnt + 1) % 4;
      gen_pulse = pulse_en && (cnt == 0);
    end
  end

  // Scoreboard: compare each delivered result with the oldest expected one.
  always @(posedge clock) begin
    if (nreset && res_valid && res_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL result_unexpected: got %h, none expected", res_sum);
      end else begin
        bf16_t e;
        e = exp_q.pop_front();
        if (res_sum !== e) begin
          tests_failed++;
          $display("FAIL result_order: got %h expected %h", res_sum, e);
        end
      end
    end
  end

  task automatic chk16(input string name, input bf16_t act, input bf16_t exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic send(input bf16_t a, input bf16_t b, input bf16_t s, input int budget);
    bit done;
    done = 1'b0;
    @(negedge clock);
    op_valid = 1'b1; op_a = a; op_b = b;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clock);
      if (op_ready) begin
        done = 1'b1;
        exp_q.push_back(s);
      end
    end
    @(negedge clock);
    op_valid = 1'b0;
    chk1("send_accepted", done, 1'b1);
  endtask

  task automatic pulse();
    @(negedge clock); man_pulse = 1'b1;
    @(negedge clock); man_pulse = 1'b0;
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !busy && !res_valid) done = 1'b1;
    end
    chk1("drain_complete", done, 1'b1);
  endtask

  initial begin
    vecs[0] = '{16'h3F80, 16'h4000, 16'h4040};
    vecs[1] = '{16'h3F80, 16'h3F80, 16'h4000};
    vecs[2] = '{16'h4040, 16'h3F80, 16'h4080};
    vecs[3] = '{16'h4120, 16'h3F00, 16'h4128};
    vecs[4] = '{16'h4000, 16'h4000, 16'h4080};
    vecs[5] = '{16'h42C8, 16'h3F80, 16'h42CA};

    nreset = 1'b0; op_valid = 1'b0; op_a = 16'h0000; op_b = 16'h0000;
    res_ready = 1'b1; man_pulse = 1'b0; pulse_en = 1'b0;
    repeat (2) @(negedge clock);
    chk1("rst_op_ready", op_ready, 1'b1);
    chk1("rst_res_valid", res_valid, 1'b0);
    chk16("rst_res_sum", res_sum, 16'h0000);
    chk16("rst_add_a", add_a, 16'h0000);
    chk16("rst_add_b", add_b, 16'h0000);
    chk1("rst_busy", busy, 1'b0);
`ifdef BF16_DRV_TIMEOUT_EN
    chk1("rst_timeout_err", timeout_err, 1'b0);
`endif
    nreset = 1'b1;

    // Pulses with nothing queued: dummy results, nothing emitted.
    pulse_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      chk16("idle_add_a", add_a, 16'h0000);
    end
    pulse_en = 1'b0;
    chk1("idle_res_valid", res_valid, 1'b0);
    chk1("idle_busy", busy, 1'b0);

    // Single operation with hand-placed pulses.
    send(16'h3F80, 16'h4000, 16'h4040, 4);
    @(negedge clock); man_pulse = 1'b1;
    chk16("single_add_a", add_a, 16'h3F80);
    @(negedge clock); man_pulse = 1'b0;
    chk16("single_add_b", add_b, 16'h4000);
    chk16("single_add_a_after", add_a, 16'h0000);
    chk1("single_busy", busy, 1'b1);
    repeat (2) @(negedge clock);
    pulse();
    chk1("single_res_valid", res_valid, 1'b1);
    chk16("single_res_sum", res_sum, 16'h4040);
    @(negedge clock);
    chk1("single_once", res_valid, 1'b0);
    drain(20);

    // Table-driven stream with periodic pulses.
    pulse_en = 1'b1;
    for (int i = 0; i < 6; i++) send(vecs[i].a, vecs[i].b, vecs[i].s, 40);
    drain(100);
    pulse_en = 1'b0;

    // Fill the operand FIFO with no pulses; the fifth pair waits for a pop.
    for (int i = 0; i < 4; i++) send(vecs[i].a, vecs[i].b, vecs[i].s, 4);
    chk1("full_op_ready", op_ready, 1'b0);
    fork
      send(vecs[4].a, vecs[4].b, vecs[4].s, 40);
      begin
        repeat (3) @(negedge clock);
        chk1("full_held", op_ready, 1'b0);
        pulse_en = 1'b1;
      end
    join
    drain(100);
    pulse_en = 1'b0;

    // Result backpressure: only two results buffered, issue stalls, nothing lost.
    res_ready = 1'b0;
    pulse_en  = 1'b1;
    for (int i = 0; i < 4; i++) send(vecs[i+1].a, vecs[i+1].b, vecs[i+1].s, 40);
    repeat (30) @(negedge clock);
    chk1("bp_res_valid", res_valid, 1'b1);
    chk16("bp_no_issue", add_a, 16'h0000);
    chk1("bp_op_ready", op_ready, 1'b1);
    chk1("bp_busy", busy, 1'b1);
    chk16("bp_queue_depth", 16'(exp_q.size()), 16'd4);
    res_ready = 1'b1;
    drain(100);
    pulse_en = 1'b0;

    // Reset while an operation is in flight with two more queued.
    for (int i = 0; i < 3; i++) send(vecs[i].a, vecs[i].b, vecs[i].s, 4);
    pulse();
    @(negedge clock);
    nreset = 1'b0;
    #1;
    chk1("mid_rst_op_ready", op_ready, 1'b1);
    chk1("mid_rst_res_valid", res_valid, 1'b0);
    chk16("mid_rst_res_sum", res_sum, 16'h0000);
    chk16("mid_rst_add_a", add_a, 16'h0000);
    chk16("mid_rst_add_b", add_b, 16'h0000);
    chk1("mid_rst_busy", busy, 1'b0);
    exp_q.delete();
    @(negedge clock);
    nreset = 1'b1;
    pulse();
    repeat (3) @(negedge clock);
    chk1("post_rst_no_result", res_valid, 1'b0);
    chk1("post_rst_busy", busy, 1'b0);
    pulse_en = 1'b1;
    send(vecs[5].a, vecs[5].b, vecs[5].s, 40);
    drain(100);
    pulse_en = 1'b0;

`ifdef BF16_DRV_TIMEOUT_EN
    // Adder never answers: watchdog drops the op, later ops still work.
    send(vecs[1].a, vecs[1].b, vecs[1].s, 4);
    pulse();
    chk1("wd_busy_inflight", busy, 1'b1);
    repeat (10) @(negedge clock);
    chk1("wd_timeout_err", timeout_err, 1'b1);
    chk1("wd_inflight_cleared", busy, 1'b0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    pulse_en = 1'b1;
    send(vecs[2].a, vecs[2].b, vecs[2].s, 40);
    drain(100);
    pulse_en = 1'b0;
    chk1("wd_sticky", timeout_err, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, failed so far %0d", tests_failed);
    $fatal(1);
  end
endmodule

// File: doc/bf16_add_driver.md
BF16_ADD_DRIVER -- requirements
Module: bf16_add_driver

Interface
REQ-001 Parameter DEPTH, default 4: operand FIFO entries; power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 64: adder-response watchdog limit in cycles, 8..255.
REQ-003 clock  in  1  clock; all state rises on posedge clock.
REQ-004 nreset  in  1  reset, asynchronous, active-low.
REQ-005 op_valid  in  1  operand pair offered; op_ready  out  1  pair accepted when both high.
REQ-006 op_a, op_b  in  16 each  bfloat16 operands.
REQ-007 res_valid  out  1 / res_ready  in  1 / res_sum  out  16  result stream, transfer when valid&ready.
REQ-008 add_a  out  16, add_b  out  16  operands driven to bfloat16_adder.
REQ-009 add_sum  in  16, add_ready  in  1  adder result and one-cycle sample/complete pulse.
REQ-010 busy  out  1  high while an operation is in flight or the FIFO is non-empty.
REQ-011 timeout_err  out  1  sticky watchdog flag (present only with macro, REQ-027).

Function
REQ-012 Adder protocol: each add_ready pulse samples add_a at that edge and add_b at the following edge, and marks completion (add_sum valid) of the previously sampled pair.
REQ-013 Operand FIFO, DEPTH entries; op_ready = not full; push on op_valid&op_ready.
REQ-014 add_a = FIFO head a when non-empty and issue permitted, else 16'h0000.
REQ-015 add_b = issued_b register, loaded with head b on the issuing edge and held until the next issue.
REQ-016 Issue at an add_ready edge when FIFO non-empty and result buffer has a free entry after counting the result captured at that edge; issue pops FIFO and sets inflight.
REQ-017 At an add_ready edge with inflight set, add_sum is written into result buffer; inflight then equals whether an issue occurred on the same edge.
REQ-018 Pulses with inflight clear capture nothing (dummy adder results discarded).
REQ-019 Result buffer: 2-entry FIFO; res_valid = non-empty; res_sum = head; pop on res_valid&res_ready.
REQ-020 Simultaneous push and pop on either FIFO at full or empty is legal; occupancy unchanged when both occur.
REQ-021 Pointers wrap modulo DEPTH (operand) and modulo 2 (result); occupancy counter width clog2(DEPTH)+1.
REQ-022 Ordering: results emerge in operand-acceptance order, one result per accepted pair, none lost or duplicated.
REQ-023 Latency: pair at FIFO head issued at next add_ready pulse; result valid the cycle after the following pulse.
REQ-024 Operand values pass untouched; no arithmetic on data in this block.

Reset
REQ-025 On nreset low: FIFOs empty, inflight=0, issued_b=0, watchdog=0, timeout_err=0; outputs op_ready=1, res_valid=0, res_sum=0, add_a=0, add_b=0, busy=0.
REQ-026 Reset mid-operation discards queued pairs and the in-flight operation; first post-reset add_ready pulse is treated as dummy.

Configuration
REQ-027 Macro BF16_DRV_TIMEOUT_EN defined: counter runs while inflight, clears on add_ready; reaching TIMEOUT sets timeout_err sticky until reset, clears inflight, drops the lost result; undefined: no counter, no timeout_err port, inflight waits indefinitely.

Structure
REQ-028 Package bf16_pkg holds typedef bf16_t (16-bit), BF16_W=16, and localparam defaults for DEPTH and TIMEOUT.
REQ-029 One sub-module sync_fifo (parameterised width/depth, full/empty/count) instantiated for operand (32-bit) and result (16-bit) buffers.

Verification
REQ-030 Single op 16'h3F80 + 16'h4000 with adder model -> add_a=3F80 at sample pulse, add_b=4000 next cycle, res_sum=16'h4040 once.
REQ-031 Push 5 pairs with DEPTH=4, no pulses -> op_ready low after 4th, 5th held until pop; results in push order.
REQ-032 res_ready held low, 4 pairs queued -> at most 2 results buffered, no further issue, no loss; release -> all 4 delivered in order.
REQ-033 add_ready pulses with empty FIFO -> add_a=0000, no res_valid, inflight stays 0.
REQ-034 nreset asserted while inflight with 2 queued -> all outputs at reset values immediately; next pulse produces no result.
REQ-035 BF16_DRV_TIMEOUT_EN, TIMEOUT=8, issue then withhold add_ready 8 cycles -> timeout_err=1 sticky, inflight=0, next pair still issues normally.
